uart_receive: RTL and testbench
===============================

Name: uart_receive

Overview:
- UART receiver: the receive end of the serial link driven by the team's `send` transmitter. Frame format is 8N1: start bit, 8 data bits LSB-first, 1 stop bit, no parity.
- Bit time is WTIME clocks, the same parameter as `send`.
- Sits between the board RX pin and the CPU I/O path. Presents each received byte with a one-cycle valid strobe.

Parameters:
- WTIME, 10: clocks per bit. Legal range is 4 or more. The half-bit point is WTIME/2 (integer division).
- DATA_WIDTH, 8: data bits per frame.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- UART_RX  in  1  serial line, idles high, asynchronous to CLOCK.
- data  out  DATA_WIDTH  last correctly framed byte.
- valid  out  1  one-cycle pulse: data was just updated.
- frame_err  out  1  one-cycle pulse: stop bit was sampled low.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset and clock (already decided): one clock, CLOCK; reset RESET is asynchronous and active-low. While RESET=0:
  - state=IDLE, counters=0, shift register=0;
  - data=0, valid=0, frame_err=0, busy=0;
  - both synchronizer flops=1.
- Synchronizer: UART_RX passes through 2 flops to give rx_s. Only rx_s is used internally.
- States: IDLE, START, DATA, STOP, BREAK. busy = (state != IDLE).
- IDLE:
  - rx_s==0 -> START, clk_cnt=0.
- START:
  - At clk_cnt==WTIME/2-1, sample rx_s.
  - 0 -> DATA, clk_cnt=0, bit_cnt=0.
  - 1 -> IDLE (glitch reject, no outputs).
- DATA:
  - At clk_cnt==WTIME-1, sample rx_s into the shift register, shifting right with the sample entering at the MSB. This yields LSB-first order.
  - On the same cycle, clk_cnt=0 and bit_cnt++.
  - After bit DATA_WIDTH-1 -> STOP.
- STOP:
  - At clk_cnt==WTIME-1, sample rx_s.
  - 1 -> data<=shift register, valid=1 for the next cycle only, -> IDLE.
  - 0 -> frame_err=1 for the next cycle only, data unchanged, -> BREAK.
- BREAK:
  - Stay until rx_s==1, then -> IDLE. This stops a held-low line from producing repeated frames.
- Timing:
  - Let t0 = the first edge where IDLE sees rx_s==0.
  - Sample edges fall at t0 + WTIME/2 + k*WTIME: k=0 is the start bit, k=1..8 the data bits, k=9 the stop bit.
  - valid or frame_err is high exactly one cycle, starting on the edge after the stop sample.
  - Pin-to-t0 latency is 2-3 clocks (synchronizer).
- Back-to-back frames: a start bit immediately after the stop bit must be accepted. IDLE is re-entered before the next falling edge can reach rx_s.
- valid and frame_err are never both high.
- data holds its value until the next good frame.
- Counter widths: clk_cnt is $clog2(WTIME) bits; bit_cnt is $clog2(DATA_WIDTH+1) bits. Counters do not wrap outside their state.
- Reset mid-frame: the partial frame is discarded. No valid or frame_err pulse is produced at or after reset release.

Decomposition:
- Add RX_STATE_TYPE (enum IDLE/START/DATA/STOP/BREAK) to typedef_collection.sv.
- Add a UART_DATA_TYPE typedef (DATA_WIDTH-bit), shared with `send`.
- Sub-module sync_2ff: 2-flop synchronizer with a reset value port, instantiated once here.

Test Plan (WTIME=10, serial driver in the bench):
- Frame 0x67 with a correct stop bit -> valid pulses for 1 cycle and data=8'h67; frame_err stays 0; busy=1 from about t0 to the valid cycle, then 0.
- UART_RX low for 3 clocks then high -> START rejects it; no valid or frame_err; busy returns to 0 within WTIME/2+1 clocks.
- Frame 0xA5 with stop bit driven 0, line then held low for 50 clocks, then high -> frame_err pulses once; data stays 8'h67; busy stays 1 until rx_s goes high, then IDLE; no second frame.
- Frames 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses exactly 10*WTIME clocks apart; data=8'h00 then 8'hFF.
- RESET=0 asserted during data bit 4 of 0x3C, released 2 clocks later, then frame 0x81 sent -> no pulse for 0x3C; data=8'h00 after reset; then valid with data=8'h81.

Source files
------------

// File: rtl/uart_receive_pkg.sv
// Shared types for the UART receive path: receiver FSM states and the byte type
// also used by the transmitter.
package uart_receive_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef logic [UART_DATA_WIDTH-1:0] UART_DATA_TYPE;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } RX_STATE_TYPE;

endpackage

// File: rtl/uart_receive_sync_2ff.sv
// Two-flop synchronizer for signals crossing into the clk domain; the reset value
// is a port so an idle-high line can come out of reset without a false edge.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its source; with = the two stages would collapse into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= rst_val;
            sync_q <= rst_val;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver: samples mid-bit from the detected start edge, presents each
// good byte with a one-cycle valid strobe and flags bad stop bits with frame_err.
module uart_receive
    import uart_receive_pkg::*;
#(
    parameter int WTIME      = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  UART_RX,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(WTIME);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(WTIME / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(WTIME - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    logic rx_s;

    RX_STATE_TYPE          state_q,     state_d;
    logic [CNT_W-1:0]      clk_cnt_q,   clk_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic                  valid_q,     valid_d;
    logic                  frame_err_q, frame_err_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk     (CLOCK),
        .rst_n   (RESET),
        .rst_val (1'b1),
        .d       (UART_RX),
        .q       (rx_s)
    );

    // NOTE: every variable gets its hold/default value before the case so no
    // path through this block leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end

            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    // A start bit that is already gone by mid-bit was a glitch.
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (clk_cnt_q == FULL_LAST) begin
                    shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    clk_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            BREAK: begin
                // Wait out a held-low line so it cannot retrigger as new frames.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the shift register is reset along with the control state so a frame
    // cut short by reset can never leak stale bits into a later byte.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: a serial driver pushes the expected outcome of each frame
// into a scoreboard queue; a monitor pops and compares on every valid/frame_err pulse.
module tb_uart_receive;
    import uart_receive_pkg::*;

    localparam int WTIME = 10;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic          UART_RX = 1'b1;
    UART_DATA_TYPE data;
    logic          valid;
    logic          frame_err;
    logic          busy;

    typedef struct packed {
        logic          is_err;
        UART_DATA_TYPE data;
    } exp_t;

    exp_t          exp_q[$];
    int            pulse_cycles[$];
    UART_DATA_TYPE last_good = '0;
    int            checks = 0;
    int            failures = 0;
    int            cycle = 0;
    logic          prev_pulse = 1'b0;
    exp_t          mon_e;

    uart_receive #(
        .WTIME      (WTIME),
        .DATA_WIDTH (8)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .UART_RX   (UART_RX),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Scoreboard monitor: outputs are sampled on the falling edge, away from updates.
    always @(negedge CLOCK) begin
        if (RESET) begin
            if (valid || frame_err) begin
                check("pulse_width", {31'd0, prev_pulse}, 32'd0);
                check("valid_and_err", {31'd0, valid & frame_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
                    check("pulse_data", {24'd0, data}, {24'd0, mon_e.data});
                end
                if (valid) pulse_cycles.push_back(cycle);
            end
            prev_pulse = valid | frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic drive_bit(input logic b);
        UART_RX = b;
        repeat (WTIME) @(negedge CLOCK);
    endtask

    task automatic send_frame(input UART_DATA_TYPE b, input logic stop_ok);
        if (stop_ok) begin
            exp_q.push_back('{is_err: 1'b0, data: b});
            last_good = b;
        end else begin
            exp_q.push_back('{is_err: 1'b1, data: last_good});
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i]);
            if (i == 3) check("busy_mid_frame", {31'd0, busy}, 32'd1);
        end
        drive_bit(stop_ok);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 30 * WTIME) begin
            @(negedge CLOCK);
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge CLOCK);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n0;
        UART_DATA_TYPE b;
        logic ok;
        UART_DATA_TYPE part;

        // Reset state.
        repeat (3) @(negedge CLOCK);
        check("reset_data", {24'd0, data}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        RESET = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Good frame 0x67.
        send_frame(8'h67, 1'b1);
        drive_bit(1'b1);
        wait_drain("drain_67");
        check("data_67", {24'd0, data}, 32'h67);
        check("idle_after_67", {31'd0, busy}, 32'd0);

        // Short low glitch is rejected by the start-bit check.
        UART_RX = 1'b0;
        repeat (3) @(negedge CLOCK);
        UART_RX = 1'b1;
        wait_idle("glitch_busy_clear", WTIME / 2 + 4);
        drive_bit(1'b1);
        check("glitch_data_kept", {24'd0, data}, 32'h67);

        // Bad stop bit followed by a held-low line: one frame_err, no extra frames.
        send_frame(8'hA5, 1'b0);
        repeat (50) @(negedge CLOCK);
        check("break_busy", {31'd0, busy}, 32'd1);
        check("break_err_seen", exp_q.size(), 32'd0);
        check("break_data_kept", {24'd0, data}, 32'h67);
        UART_RX = 1'b1;
        wait_idle("break_exit", 8);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Back-to-back frames with no idle gap.
        n0 = pulse_cycles.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive_bit(1'b1);
        wait_drain("drain_b2b");
        check("b2b_pulse_count", pulse_cycles.size() - n0, 32'd2);
        if (pulse_cycles.size() - n0 == 2)
            check("b2b_spacing", pulse_cycles[n0+1] - pulse_cycles[n0], 10 * WTIME);
        check("data_ff", {24'd0, data}, 32'hFF);

        // Reset in the middle of data bit 4 of 0x3C.
        part = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(part[i]);
        UART_RX = part[4];
        repeat (5) @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        check("midreset_data", {24'd0, data}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        @(negedge CLOCK);
        RESET = 1'b1;
        UART_RX = 1'b1;
        last_good = '0;
        for (int i = 0; i < 12; i++) drive_bit(1'b1);
        check("post_reset_data", {24'd0, data}, 32'd0);
        check("post_reset_no_pulse", exp_q.size(), 32'd0);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1);
        wait_drain("drain_81");
        check("data_81", {24'd0, data}, 32'h81);

        // Randomized frames, occasionally with a bad stop bit.
        for (int f = 0; f < 12; f++) begin
            b  = UART_DATA_TYPE'($urandom_range(255, 0));
            ok = ($urandom_range(3, 0) != 0);
            send_frame(b, ok);
            if (!ok) begin
                UART_RX = 1'b1;
                drive_bit(1'b1);
                if ($urandom_range(1, 0) != 0) drive_bit(1'b1);
            end else if ($urandom_range(1, 0) != 0) begin
                drive_bit(1'b1);
            end
        end
        drive_bit(1'b1);
        wait_drain("drain_random");
        check("final_data", {24'd0, data}, {24'd0, last_good});
        wait_idle("final_idle", 4 * WTIME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
